// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the buffered UART receiver.
// Contents: default bit timing (shared with uart_tx), data width and the
// one-hot receiver FSM state encoding.
package uart_rx_buffered_pkg;

  // 100 MHz system clock, 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned DATA_W               = 8;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_START     = 5'b00010,
    ST_DATA      = 5'b00100,
    ST_STOP      = 5'b01000,
    ST_WAIT_HIGH = 5'b10000
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   i_Clock, i_Reset        clock, synchronous active-high reset
//   i_Push, i_Push_Data     write request and data
//   i_Pop                   read request, ignored while empty
//   o_Valid                 FIFO not empty
//   o_Head                  head entry; holds its last value while empty
//   o_Count                 occupancy 0..DEPTH
//   o_Overflow              one-cycle pulse when a push is dropped
module sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Push,
  input  logic [WIDTH-1:0]  i_Push_Data,
  input  logic              i_Pop,
  output logic              o_Valid,
  output logic [WIDTH-1:0]  o_Head,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W:0]   count_next;
  logic              do_pop;
  logic              do_push;

  // Full/empty come from the occupancy count; a pop frees the slot a
  // same-cycle push needs when full.
  always_comb begin
    do_pop     = i_Pop && (o_Count != '0);
    do_push    = i_Push && ((o_Count != FULL_COUNT) || do_pop);
    rd_next    = rd_ptr + ADDR_W'(do_pop);
    count_next = o_Count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
  end

  // Storage array
  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr] <= i_Push_Data;
  end

  // Pointers, count and registered head
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Valid    <= 1'b0;
      o_Head     <= '0;
      o_Overflow <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + ADDR_W'(do_push);
      rd_ptr     <= rd_next;
      o_Count    <= count_next;
      o_Valid    <= (count_next != '0);
      o_Overflow <= i_Push && !do_push;
      // New head bypasses the array when it is being written this cycle
      if (count_next != '0) begin
        if (do_push && (wr_ptr == rd_next)) o_Head <= i_Push_Data;
        else                                o_Head <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Buffered 8N1 UART receiver (LSB first, idle-high line).
// Two-flop input synchronizer, mid-bit sampling, start-bit glitch
// rejection, framing-error and break detection, FWFT byte FIFO.
// Ports:
//   i_Clock, i_Reset   clock, synchronous active-high reset
//   i_RX_Serial        asynchronous serial input
//   i_RX_Rd            pop request, acts only while o_RX_DV=1
//   o_RX_DV            FIFO not empty
//   o_RX_Byte          FIFO head byte
//   o_Count            FIFO occupancy
//   o_Frame_Err        pulse: stop bit low, nonzero data
//   o_Break            pulse: stop bit low, data 0x00
//   o_Overflow         pulse: good byte dropped, FIFO full
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_RX_Serial,
  input  logic              i_RX_Rd,
  output logic              o_RX_DV,
  output logic [DATA_W-1:0] o_RX_Byte,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Frame_Err,
  output logic              o_Break,
  output logic              o_Overflow
);

  localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e         state;
  logic              rx_meta;
  logic              rx_sync;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic              frame_err_q;
  logic              break_q;
  logic              push_c;

  // Good stop bit on the sample cycle pushes straight into the FIFO
  assign push_c = (state == ST_STOP) && (clk_cnt == FULL_CNT) && rx_sync;

  // Synchronizer and receiver FSM
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      state       <= ST_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      rx_meta     <= i_RX_Serial;
      rx_sync     <= rx_meta;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= ST_START;
        end
        ST_START: begin
          // Line must still be low half a bit later, else it was a glitch
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt            <= '0;
            shift_reg[bit_idx] <= rx_sync;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT_HIGH;
              if (shift_reg == '0) break_q     <= 1'b1;
              else                 frame_err_q <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_HIGH: begin
          // Held-low line reports once, then waits for idle
          clk_cnt <= '0;
          if (rx_sync) state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          clk_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  assign o_Frame_Err = frame_err_q;
  assign o_Break     = break_q;

  sync_fifo #(
    .WIDTH  (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Push      (push_c),
    .i_Push_Data (shift_reg),
    .i_Pop       (i_RX_Rd),
    .o_Valid     (o_RX_DV),
    .o_Head      (o_RX_Byte),
    .o_Count     (o_Count),
    .o_Overflow  (o_Overflow)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_uart_rx_buffered;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  // Edges from start-bit drive to the stop-sample edge: 3 + (CPB-1)/2 + 1 + 9*CPB
  localparam int unsigned STOP_EDGE = 3 + (CPB - 1) / 2 + 1 + 9 * CPB;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          rx    = 1'b1;
  logic          rd    = 1'b0;
  logic          dv;
  logic [7:0]    rx_byte;
  logic [AW:0]   count;
  logic          ferr;
  logic          brk;
  logic          ovf;

  int errors = 0;
  int checks = 0;
  int ferr_seen = 0, brk_seen = 0, ovf_seen = 0;
  int ferr_base = 0, brk_base = 0, ovf_base = 0;
  int exp_ovf = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (AW)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (reset),
    .i_RX_Serial (rx),
    .i_RX_Rd     (rd),
    .o_RX_DV     (dv),
    .o_RX_Byte   (rx_byte),
    .o_Count     (count),
    .o_Frame_Err (ferr),
    .o_Break     (brk),
    .o_Overflow  (ovf)
  );

  // Pulse monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (ferr) ferr_seen++;
    if (brk)  brk_seen++;
    if (ovf)  ovf_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives one frame; entered and left at posedge+1
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_dv"}, 32'(dv), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, 32'(rx_byte), 32'(exp_q[0]));
  endtask

  task automatic send_good(input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else                      exp_ovf++;
    send_frame(d, 1'b1);
    check_state("rx");
  endtask

  task automatic pop_check();
    check("pop_dv", 32'(dv), 32'd1);
    if (exp_q.size() != 0) begin
      check("pop_byte", 32'(rx_byte), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    check_state("after_pop");
  endtask

  task automatic check_flags(input string tag, input int fe, input int br);
    check({tag, "_frame_err"}, 32'(ferr_seen - ferr_base), 32'(fe));
    check({tag, "_break"}, 32'(brk_seen - brk_base), 32'(br));
    check({tag, "_overflow"}, 32'(ovf_seen - ovf_base), 32'(exp_ovf));
    ferr_base = ferr_seen;
    brk_base  = brk_seen;
    ovf_base  = ovf_seen;
    exp_ovf   = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_dv", 32'(dv), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_byte", 32'(rx_byte), 32'h00);
    check("reset_pulses", 32'({ferr, brk, ovf}), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // 0x55 with exact DV latency, then 0xA3
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        check("dv_before_stop", 32'(dv), 32'd0);
        @(posedge clk);
        #1;
        check("dv_after_stop", 32'(dv), 32'd1);
        check("first_byte", 32'(rx_byte), 32'h55);
        check("first_count", 32'(count), 32'd1);
      end
    join
    send_good(8'hA3);
    pop_check();
    pop_check();
    check("head_holds", 32'(rx_byte), 32'hA3);
    check_flags("basic", 0, 0);

    // Short low glitch is rejected
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check_state("glitch");
    check_flags("glitch", 0, 0);
    send_good(8'h7E);
    pop_check();

    // Framing error, then recovery
    send_frame(8'h3C, 1'b0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    check_state("frame");
    check_flags("frame", 1, 0);
    send_good(8'h3C);
    pop_check();

    // Long break reports once
    rx = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check_state("break");
    check_flags("break", 0, 1);
    send_good(8'h41);
    pop_check();

    // Overflow on the fifth byte
    for (int i = 1; i <= 5; i++) send_good(8'(i));
    check_flags("overflow", 0, 0);
    for (int i = 0; i < 4; i++) pop_check();

    // Full FIFO, pop coincides with the stop sample of byte 5
    for (int i = 1; i <= 4; i++) send_good(8'(i));
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        check("full_pop_head", 32'(rx_byte), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        exp_q.push_back(8'h05);
        check("full_pop_count", 32'(count), 32'(DEPTH));
        check("full_pop_new_head", 32'(rx_byte), 32'h02);
      end
    join
    check_flags("full_pop", 0, 0);
    for (int i = 0; i < 4; i++) pop_check();

    // Reset during data bit 3 flushes and abandons the frame
    send_good(8'h5A);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check("midreset_dv", 32'(dv), 32'd0);
    check("midreset_count", 32'(count), 32'd0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    send_good(8'h99);
    pop_check();
    check_flags("midreset", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
- UART receiver: the receive-side counterpart to the existing uart_tx. 8N1 format, LSB first, idle-high line.
- Oversampled by the system clock; mid-bit sampling; start-bit glitch rejection; framing-error and break detection.
- Received bytes go into a small first-word-fall-through FIFO, so the top-level FSM can consume console input at its own pace.
- Sits beside uart_tx in the top level, driven by the board uart_rx pin.

Parameters:
- CLKS_PER_BIT, 868: system clocks per bit (100 MHz / 115200). Must be >= 8.
- FIFO_DEPTH, 16: FIFO entries. Power of two, >= 2.
- ADDR_W, 4: log2(FIFO_DEPTH). Derived; not overridden independently.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  synchronous reset, active-high.
- i_RX_Serial  in  1  asynchronous serial input, idle high.
- i_RX_Rd  in  1  pop request. Acts only when o_RX_DV=1.
- o_RX_DV  out  1  FIFO not empty.
- o_RX_Byte  out  8  FIFO head byte. Valid while o_RX_DV=1; holds the last head value otherwise.
- o_Count  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
- o_Frame_Err  out  1  one-cycle pulse: stop bit low with nonzero data.
- o_Break  out  1  one-cycle pulse: break detected (data 0x00, stop low).
- o_Overflow  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - o_RX_DV=0, o_Count=0, o_RX_Byte=0x00, all pulses 0.
  - FIFO pointers 0, FSM in IDLE, bit counters 0.
  - Synchronizer flops preset to 1 (idle).
- Input synchronizer: two flops on i_RX_Serial. The FSM sees only the synchronized signal (2-cycle latency).
- Clock counter: clk_cnt runs 0..CLKS_PER_BIT-1. bit_idx runs 0..7.
- FSM states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: on synchronized line = 0, clear clk_cnt and go to START.
  - START: when clk_cnt = (CLKS_PER_BIT-1)/2 (integer division):
    - if line still 0, clear clk_cnt and go to DATA;
    - else treat as a glitch and return to IDLE, with no flags.
  - DATA: when clk_cnt = CLKS_PER_BIT-1, shift the line into bit bit_idx (LSB first) and clear clk_cnt. After bit 7, go to STOP.
  - STOP: when clk_cnt = CLKS_PER_BIT-1, sample the stop bit:
    - 1: push the byte, then go to IDLE;
    - 0 with data = 0x00: pulse o_Break, go to WAIT_HIGH, no push;
    - 0 with data != 0x00: pulse o_Frame_Err, go to WAIT_HIGH, no push.
  - WAIT_HIGH: stay until the synchronized line = 1, then go to IDLE. A long break yields exactly one o_Break.
- Push timing: the push occurs on the stop-sample cycle. o_RX_DV and o_Count update on the next clock edge.
- Pop: when i_RX_Rd=1 and o_RX_DV=1, the read pointer advances and the next head appears on the following cycle (FWFT). i_RX_Rd while empty is ignored, with no pointer change.
- Full FIFO:
  - a push with no pop in the same cycle drops the new byte and pulses o_Overflow; FIFO contents are unchanged;
  - a push and a pop in the same cycle while full both succeed; o_Count stays FIFO_DEPTH; no overflow.
- Simultaneous push and pop at any other occupancy: both occur; o_Count unchanged.
- Pointer arithmetic:
  - pointers are ADDR_W bits and wrap modulo FIFO_DEPTH;
  - full/empty are derived from o_Count, not from pointer equality alone.
- Reset mid-frame: abandon the frame immediately, flush the FIFO, return to IDLE. The next falling edge after reset starts a fresh frame.
- No parity support; no baud auto-detect.

Decomposition:
- Shared package/header (uart_defs.vh):
  - FSM state localparams (one-hot, matching the team's FSM style);
  - default CLKS_PER_BIT for 100 MHz/115200, shared with uart_tx.
- One sub-module: sync_fifo, with parameters WIDTH=8, DEPTH. It provides push/pop/count/overflow.
- The receiver FSM and synchronizer stay in uart_rx_buffered.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
- Send 0x55, then 0xA3, with correct stop bits:
  - o_RX_DV rises 1 cycle after the first stop sample;
  - o_RX_Byte=0x55, then 0xA3 after one i_RX_Rd pulse;
  - o_Count goes 1→2→1→0.
- Low glitch of 5 cycles on an idle line: no byte, no flags, FSM back in IDLE; a following 0x7E is received correctly.
- Frame 0x3C with stop bit forced 0: one o_Frame_Err pulse, o_Count stays 0; after the line returns high, 0x3C with a good stop is received.
- Line held low for 30 bit times: exactly one o_Break pulse, no push; a later 0x41 is received.
- Send 5 bytes (0x01..0x05) with no reads: o_Count=4, one o_Overflow pulse on byte 5; reads return 0x01..0x04.
- Full FIFO with i_RX_Rd held on the stop-sample cycle of byte 5: no overflow, o_Count stays 4, head = 0x02.
- Assert i_Reset during DATA bit 3: o_RX_DV=0 and o_Count=0 the next cycle; a subsequent 0x99 is received correctly.
